argmax_seq: RTL
===============

Name: argmax_seq

Overview:
- Sequential argmax controller for the BNN classifier output stage.
- Takes a packed vector of N class scores on a start pulse and scans it with one shared K-bit comparator, one score per cycle.
- Returns the winning class index and its score with a busy/done handshake.
- Trades the combinational comparator tree for N-1 cycles of latency, for area-constrained printed targets.

Parameters:
- N, 8, number of class scores (N >= 1).
- K, 4, width of each score in bits.
- I, 4, width of the index output; 2^I >= N required.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request to begin a scan; sampled on rising edge.
- inx  input  N*K  packed scores; element j = inx[j*K +: K]; sampled only on the accepting edge.
- busy  output  1  high while scanning (state SCAN).
- done  output  1  one-cycle pulse; result valid (state DONE).
- outimax  output  I  index of the maximum score from the last completed scan.
- outmax  output  K  value of the maximum score from the last completed scan.

Behaviour:
- Reset values:
  - State IDLE; busy=0, done=0, outimax=0, outmax=0.
  - Internal buffer, running max, running index and counter cleared.
- States:
  - IDLE, SCAN, DONE.
  - busy = (state==SCAN); done = (state==DONE); both are decoded directly from registered state.
- Accept:
  - Condition: start=1 on an edge with state IDLE or DONE.
  - Action: latch inx into the internal buffer, running max <= element 0, running index <= 0, counter <= 1.
  - Next state: SCAN, or DONE directly if N==1 (running values are copied to outputs on that same edge).
- SCAN, each edge:
  - Compare element[counter] against running max, unsigned.
  - Replace max and index only if strictly greater, so ties keep the lowest index.
  - If counter==N-1: copy the final running max/index (including this edge's comparison) into outmax/outimax and go to DONE.
  - Otherwise: counter++.
- start is ignored in SCAN: no restart, and inx is not resampled.
- DONE:
  - Lasts exactly one cycle.
  - Next state is IDLE, or SCAN if start=1 on that edge (back-to-back scans).
- Latency:
  - Define start as sampled at edge E0.
  - done is high between edge E(N-1) and edge EN; for N=8, done is high after the 7th edge following E0.
- Output hold:
  - outimax/outmax change only on entry to DONE.
  - They hold their values through IDLE and through a subsequent scan until the next completion.
- Counter width is I bits. The counter never wraps because the scan terminates at N-1.
- Reset mid-operation: rst=1 in any state forces the reset values on that edge. The aborted scan produces no done pulse.
- rst has priority over start when both are asserted on the same edge.

Optional Feature:
- Macro: ARGMAX_SIGNED_EN.
- Defined: scores are compared as K-bit two's complement.
- Undefined: scores are compared as unsigned.
- Tie rule (lowest index wins) and timing are identical in both modes.

Test Plan:
1. Basic scan:
   - Stimulus: reset, then start=1 for one cycle with inx=32'h12e9f3d3 (elements LSB-first: 3,D,3,F,9,E,2,1).
   - Required: busy for 7 cycles, then a single-cycle done; outimax=3, outmax=F.
   - With ARGMAX_SIGNED_EN: outimax=0, outmax=3 (tie with index 2 resolves low).
2. Ties and edges:
   - inx=32'h77777777 -> outimax=0, outmax=7.
   - inx=32'hF0000000 -> outimax=7, outmax=F.
   - inx=32'h0000000F -> outimax=0, outmax=F.
3. Start while busy:
   - Stimulus: start with 32'h12e9f3d3, then start again at edge E3 with inx=32'hF0000000.
   - Required: the second request is ignored; done occurs at E7 with outimax=3; no second done follows.
4. Back-to-back:
   - Stimulus: assert start during the DONE cycle with inx=32'hF0000000.
   - Required: first result outimax=3, then a second done 7 edges later with outimax=7.
   - busy low only during the DONE cycle.
5. Reset mid-scan:
   - Stimulus: assert rst at E4.
   - Required: busy=0, done never pulses, outimax=0, outmax=0.
   - Required afterwards: a new start with 32'h12e9f3d3 completes normally with outimax=3.
6. Output hold:
   - Stimulus: after a completed scan, hold start=0 for 20 cycles.
   - Required: outimax/outmax stable, done=0, busy=0.

Source files
------------

// File: rtl/argmax_seq_if.sv
// Handshake and data bundle for the sequential argmax controller.
// The master drives start/inx; the slave (argmax_seq) returns status and result.
interface argmax_seq_if #(
    parameter int N = 8,
    parameter int K = 4,
    parameter int I = 4
);
    logic           start;
    logic [N*K-1:0] inx;
    logic           busy;
    logic           done;
    logic [I-1:0]   outimax;
    logic [K-1:0]   outmax;

    modport master (output start, output inx, input busy, input done, input outimax, input outmax);
    modport slave  (input start, input inx, output busy, output done, output outimax, output outmax);
endinterface

// File: rtl/argmax_seq.sv
// Sequential argmax: scans N packed K-bit scores with one shared comparator.
// Define ARGMAX_SIGNED_EN to compare scores as two's complement instead of unsigned.
module argmax_seq #(
    parameter int N = 8,
    parameter int K = 4,
    parameter int I = 4
) (
    input  logic         clk,
    input  logic         rst,
    argmax_seq_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [I-1:0] LAST_IDX = I'(N - 1);
    // A single-score vector has nothing to scan, so acceptance goes straight to DONE.
    localparam state_t START_NEXT = (N == 1) ? DONE : SCAN;

    function automatic logic score_gt(input logic [K-1:0] a, input logic [K-1:0] b);
`ifdef ARGMAX_SIGNED_EN
        return $signed(a) > $signed(b);
`else
        return a > b;
`endif
    endfunction

    state_t         state_r;
    state_t         state_s;
    logic [N*K-1:0] buf_r;
    logic [K-1:0]   max_r;
    logic [I-1:0]   idx_r;
    logic [I-1:0]   cnt_r;
    logic [I-1:0]   outimax_r;
    logic [K-1:0]   outmax_r;
    logic           accept_s;
    logic           last_s;
    logic           gt_s;
    logic [K-1:0]   cur_s;
    logic [K-1:0]   cand_max_s;
    logic [I-1:0]   cand_idx_s;
    logic           busy_s;
    logic           done_s;

    // Current score selection and strict-greater compare (ties keep the lower index).
    always_comb begin
        accept_s   = bus.start && ((state_r == IDLE) || (state_r == DONE));
        last_s     = (cnt_r == LAST_IDX);
        cur_s      = buf_r[int'(cnt_r) * K +: K];
        gt_s       = score_gt(cur_s, max_r);
        cand_max_s = gt_s ? cur_s : max_r;
        cand_idx_s = gt_s ? cnt_r : idx_r;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; start is ignored while scanning.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    state_s = START_NEXT;
                end else begin
                    state_s = IDLE;
                end
            end
            SCAN: begin
                if (last_s) begin
                    state_s = DONE;
                end else begin
                    state_s = SCAN;
                end
            end
            DONE: begin
                if (bus.start) begin
                    state_s = START_NEXT;
                end else begin
                    state_s = IDLE;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // Status outputs decoded from the registered state.
    always_comb begin
        busy_s = 1'b0;
        done_s = 1'b0;
        case (state_r)
            SCAN:    busy_s = 1'b1;
            DONE:    done_s = 1'b1;
            default: begin
                busy_s = 1'b0;
                done_s = 1'b0;
            end
        endcase
    end

    // Datapath: buffer capture, running max/index, and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_r     <= {(N*K){1'b0}};
            max_r     <= {K{1'b0}};
            idx_r     <= {I{1'b0}};
            cnt_r     <= {I{1'b0}};
            outimax_r <= {I{1'b0}};
            outmax_r  <= {K{1'b0}};
        end else if (accept_s) begin
            buf_r <= bus.inx;
            max_r <= bus.inx[K-1:0];
            idx_r <= {I{1'b0}};
            cnt_r <= I'(1);
            if (N == 1) begin
                outmax_r  <= bus.inx[K-1:0];
                outimax_r <= {I{1'b0}};
            end else begin
                outmax_r  <= outmax_r;
                outimax_r <= outimax_r;
            end
        end else if (state_r == SCAN) begin
            max_r <= cand_max_s;
            idx_r <= cand_idx_s;
            if (last_s) begin
                outmax_r  <= cand_max_s;
                outimax_r <= cand_idx_s;
            end else begin
                cnt_r <= cnt_r + I'(1);
            end
        end else begin
            max_r <= max_r;
        end
    end

    assign bus.busy    = busy_s;
    assign bus.done    = done_s;
    assign bus.outimax = outimax_r;
    assign bus.outmax  = outmax_r;

endmodule
